inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Pipelined RISC-V RV32I instruction encoder. It is the inverse of the immediate decoder.
- Accepts decoded fields: opcode, rd, rs1, rs2, funct3, funct7, and a 32-bit two's-complement immediate.
- Packs them into a 32-bit instruction word with the immediate scattered per I/S/B/U/J format, and range-checks the immediate.
- Emits each word with a sequential byte address. Used by the self-test program loader to fill instruction memory.

Parameters:
- BASE_ADDR, 32'h0000_0000, address tagged on the first output word after reset.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept the bundle this cycle.
- opcode  input  7  RISC-V opcode[6:0].
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct3  input  3  funct3.
- funct7  input  7  funct7 (R-type, and shift-immediate bits [31:25]).
- imm  input  32  signed immediate; for U-type, the full value whose low 12 bits must be zero.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  consumer accepts the word.
- out_inst  output  32  encoded instruction.
- out_addr  output  32  byte address of out_inst.
- out_err  output  1  this word was replaced by a NOP because of an encode error.
- err_cnt  output  ERR_W  saturating count of errored words accepted by the consumer.

Behaviour:
- Reset (asynchronous, active-high): s1_valid=0, out_valid=0, out_inst=0, out_addr=BASE_ADDR, out_err=0, err_cnt=0; in_ready=1 once rst deasserts. In-flight words are dropped.
- Pipeline:
  - S1 registers the input fields and computes range_ok.
  - S2 (output register) holds the packed word, its address and err.
  - Latency is 2 clocks from input handshake to out_valid with no stall.
  - Transfers happen when valid&&ready at the rising edge.
- Advance rules:
  - s2_free = !out_valid || out_ready.
  - S1 moves to S2 when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is combinational and does not depend on in_valid.
  - Full throughput is 1 word/clock.
- Output stability: out_inst, out_addr and out_err are held stable while out_valid && !out_ready.
- Address counter:
  - out_addr is assigned when a word loads into S2: the first word after reset gets BASE_ADDR, each later word gets the previous +4.
  - Wraps modulo 2^32.
  - Errored words still consume an address.
- Packing (imm=I):
  - I-type (jalr 1100111, load 0000011, I_op 0010011): {I[11:0],rs1,funct3,rd,opcode}.
    - Range check: -2048 ≤ I ≤ 2047.
    - I_op with funct3 001 or 101: {funct7,I[4:0],rs1,funct3,rd,opcode}. Range check: 0 ≤ I ≤ 31. funct7 must be 0000000, or 0100000 only for funct3=101.
  - S-type (store 0100011): {I[11:5],rs2,rs1,funct3,I[4:0],opcode}. Range check: -2048 ≤ I ≤ 2047.
  - B-type (branch 1100011): {I[12],I[10:5],rs2,rs1,funct3,I[4:1],I[11],opcode}. Range check: -4096 ≤ I ≤ 4094, I[0]=0.
  - U-type (lui 0110111, auipc 0010111): {I[31:12],rd,opcode}. Range check: I[11:0]=0.
  - J-type (jal 1101111): {I[20],I[10:1],I[11],I[19:12],rd,opcode}. Range check: -2^20 ≤ I ≤ 2^20-2, I[0]=0.
  - R-type (0110011): {funct7,rs2,rs1,funct3,rd,opcode}. imm is ignored; never errors.
  - Any other opcode is an error.
- Error handling:
  - On error, out_inst=32'h0000_0013 (addi x0,x0,0) and out_err=1.
  - err_cnt increments when an out_err=1 word handshakes out and saturates at all-ones.
- Simultaneous events:
  - S2 drain and S1 refill in the same cycle are legal.
  - Input accept and S1 advance in the same cycle are legal.
  - Ordering is strictly FIFO.

Test Plan:
- addi x1,x0,-1 (opcode 0010011, rd=1, funct3=000, imm=32'hFFFF_FFFF), out_ready=1 → out_inst=32'hFFF0_0093, out_err=0, out_valid exactly 2 clocks after accept, out_addr=BASE_ADDR.
- sw x2,8(x1) (store, rs1=1, rs2=2, funct3=010, imm=8) sent back-to-back after the previous case → out_inst=32'h0020_A423 at BASE_ADDR+4, one clock after the prior word.
- Branch and jump packing:
  - beq x0,x0,-4 (imm=32'hFFFF_FFFC) → 32'hFE00_0EE3.
  - jal x1,2048 (imm=32'h800) → 32'h0010_00EF.
  - beq with imm=3 → NOP with out_err=1, err_cnt=1.
- Error cases:
  - lui with imm=32'h1234_5001 → out_inst=32'h0000_0013, out_err=1, err_cnt increments.
  - Opcode 7'b1111111 → out_inst=32'h0000_0013, out_err=1, err_cnt increments.
  - slli with imm=32 → out_inst=32'h0000_0013, out_err=1, err_cnt increments.
- Backpressure: out_ready=0 with 3 bundles offered → first two accepted, then in_ready=0 and out_inst/out_addr held stable. Release out_ready → words emerge in order at BASE, +4, +8.
- Reset: assert rst mid-stream with S1 and S2 full → out_valid=0 and out_addr=BASE_ADDR immediately (asynchronous), err_cnt=0. The next word is emitted at BASE_ADDR.

Source files
------------

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - two-stage RV32I instruction encoder with immediate range check
// S1 captures fields and the range verdict; S2 holds the packed word, its address and error flag.
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_addr,
  output logic             out_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic             s1_valid_q, s1_valid_d;
  logic [6:0]       s1_op_q, s1_f7_q;
  logic [4:0]       s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [2:0]       s1_f3_q;
  logic [31:0]      s1_imm_q;
  logic             s1_ok_q, range_ok_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_inst_q, out_addr_q, next_addr_q;
  logic             out_err_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [31:0]      packed_d;

  logic s2_free, s1_adv, in_fire, out_fire;
  logic imm12_ok, imm13_ok, imm21_ok, shamt_ok;

  assign s2_free  = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Signed-range checks reduce to "all bits above the field equal the sign bit".
  assign imm12_ok = (imm[31:11] == {21{imm[31]}});
  assign imm13_ok = (imm[31:12] == {20{imm[31]}}) && !imm[0];
  assign imm21_ok = (imm[31:20] == {12{imm[31]}}) && !imm[0];
  assign shamt_ok = (imm[31:5] == 27'd0) &&
                    ((funct7 == 7'b0000000) || (funct3 == 3'b101 && funct7 == 7'b0100000));

  always_comb begin
    range_ok_d = 1'b0;
    case (opcode)
      OP_JALR, OP_LOAD, OP_STORE: range_ok_d = imm12_ok;
      OP_IMM:    range_ok_d = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt_ok : imm12_ok;
      OP_BRANCH: range_ok_d = imm13_ok;
      OP_LUI, OP_AUIPC: range_ok_d = (imm[11:0] == 12'd0);
      OP_JAL:    range_ok_d = imm21_ok;
      OP_REG:    range_ok_d = 1'b1;
      default:   range_ok_d = 1'b0;
    endcase
  end

  always_comb begin
    packed_d = NOP;
    case (s1_op_q)
      OP_JALR, OP_LOAD:
        packed_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      OP_IMM:
        if (s1_f3_q == 3'b001 || s1_f3_q == 3'b101)
          packed_d = {s1_f7_q, s1_imm_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
        else
          packed_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      OP_STORE:
        packed_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q};
      OP_BRANCH:
        packed_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                    s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      OP_LUI, OP_AUIPC:
        packed_d = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
      OP_JAL:
        packed_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12], s1_rd_q, s1_op_q};
      OP_REG:
        packed_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      default:
        packed_d = NOP;
    endcase
    if (!s1_ok_q) packed_d = NOP;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_fire)     s1_valid_d = 1'b1;
    else if (s1_adv) s1_valid_d = 1'b0;
    out_valid_d = out_valid_q;
    if (s1_adv)        out_valid_d = 1'b1;
    else if (out_fire) out_valid_d = 1'b0;
  end

  // Field capture needs no reset: s1_valid_q gates every use.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_op_q  <= opcode;
      s1_rd_q  <= rd;
      s1_rs1_q <= rs1;
      s1_rs2_q <= rs2;
      s1_f3_q  <= funct3;
      s1_f7_q  <= funct7;
      s1_imm_q <= imm;
      s1_ok_q  <= range_ok_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'd0;
      out_addr_q  <= BASE_ADDR;
      next_addr_q <= BASE_ADDR;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (s1_adv) begin
        out_inst_q  <= packed_d;
        out_addr_q  <= next_addr_q;
        next_addr_q <= next_addr_q + 32'd4;
        out_err_q   <= !s1_ok_q;
      end
      if (out_fire && out_err_q && (err_cnt_q != {ERR_W{1'b1}}))
        err_cnt_q <= err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - scoreboard bench for inst_encoder
// Driver pushes expected words into a queue; a negedge monitor pops on every output handshake.
module tb_inst_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst, out_addr;
  logic        out_err;
  logic [7:0]  err_cnt;

  inst_encoder #(.BASE_ADDR(BASE), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        pend;
  logic [31:0] exp_addr = BASE;
  int          exp_cnt = 0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", out_inst, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_inst", out_inst, e.inst);
        check("out_addr", out_addr, e.addr);
        check("out_err", {31'd0, out_err}, {31'd0, e.err});
        check("err_cnt", {24'd0, err_cnt}, exp_cnt);
        if (e.lat) check("latency", cyc - e.acc, 32'd2);
        if (e.err && exp_cnt < 255) exp_cnt++;
      end
    end
  end

  // Called at posedge+1; presents a bundle and records what it should encode to.
  task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im, input logic [31:0] e_inst, input bit e_err,
                       input bit lat);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    pend.inst = e_inst; pend.err = e_err; pend.lat = lat;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    pend.addr = exp_addr;
    pend.acc  = cyc;
    exp_addr  = exp_addr + 32'd4;
    sb.push_back(pend);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] im, input logic [31:0] e_inst, input bit e_err,
                      input bit lat);
    drive(op, d, s1, s2, f3, f7, im, e_inst, e_err, lat);
    wait_accept();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", sb.size(), 32'd0);
  endtask

  logic [31:0] hold_inst, hold_addr;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // addi x1,x0,-1 then sw x2,8(x1) back-to-back
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, 1'b1);
    send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'h0000_0008, 32'h0020_A423, 1'b0, 1'b1);
    // beq x0,x0,-4 ; jal x1,2048 ; beq imm=3 (odd offset)
    send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, 1'b0);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0, 1'b0);
    send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_0003, 32'h0000_0013, 1'b1, 1'b0);
    // lui with nonzero low bits ; illegal opcode ; slli shamt 32
    send(7'b0110111, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5001, 32'h0000_0013, 1'b1, 1'b0);
    send(7'b1111111, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_0000, 32'h0000_0013, 1'b1, 1'b0);
    send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'h0000_0020, 32'h0000_0013, 1'b1, 1'b0);
    // srai x5,x6,3 ; add x3,x1,x2
    send(7'b0010011, 5'd5, 5'd6, 5'd0, 3'b101, 7'b0100000, 32'h0000_0003, 32'h4033_5293, 1'b0, 1'b0);
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    check("err_cnt_after_errors", {24'd0, err_cnt}, 32'd4);

    // Backpressure: two accepted, third stalls while S2 holds still
    @(posedge clk); #1;
    out_ready = 1'b0;
    hold_addr = exp_addr;
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, 1'b0);
    send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'h0000_0008, 32'h0020_A423, 1'b0, 1'b0);
    drive(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'h0, 32'h0020_81B3, 1'b0, 1'b0);
    hold_inst = 32'hFFF0_0093;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_inst", out_inst, hold_inst);
      check("bp_hold_addr", out_addr, hold_addr);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept();
    drain();

    // Reset with both stages full
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_0005, 32'h0050_0093, 1'b0, 1'b0);
    send(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_0006, 32'h0060_0113, 1'b0, 1'b0);
    @(negedge clk);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_addr", out_addr, BASE);
    check("arst_err_cnt", {24'd0, err_cnt}, 32'd0);
    sb.delete();
    exp_addr = BASE;
    exp_cnt  = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
